// File: rtl/nano_pkg.sv
// nano_pkg: opcode, ALU function and sequencer state encodings shared by the nano-risc core.
package nano_pkg;
  localparam logic [1:0] OP_LD   = 2'b00;
  localparam logic [1:0] OP_ST   = 2'b01;
  localparam logic [1:0] OP_ALU  = 2'b10;
  localparam logic [1:0] OP_BNEG = 2'b11;
  localparam logic [5:0] ALU_SUB  = 6'b000001;
  localparam logic [5:0] ALU_DECR = 6'b000011;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FETCH, S_EXEC, S_HALT} state_e;
endpackage

// File: rtl/nano_seq.sv
// nano_seq: owns the instruction memory port, loads programs from the host and
// fetches/decodes instructions into one-cycle datapath strobes.
module nano_seq
  import nano_pkg::*;
#(
  parameter int IMEM_AW   = 8,
  parameter int DMEM_AW   = 6,
  parameter bit HALT_SELF = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_start,
  input  logic               run,
  input  logic               prog_valid,
  input  logic [7:0]         prog_data,
  input  logic               prog_last,
  output logic               prog_ready,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_we,
  output logic [7:0]         imem_wdata,
  input  logic [7:0]         imem_rdata,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic               acc_ld,
  output logic               dmem_we,
  output logic               alu_en,
  output logic [5:0]         alu_fn,
  input  logic               acc_neg,
  output logic               busy,
  output logic               halted,
  output logic [IMEM_AW-1:0] pc
);
  state_e state_q, state_d;
  logic [IMEM_AW-1:0] pc_q, pc_d, lp_q, lp_d, tgt;
  logic [7:0] ir_q, ir_d;
  assign tgt        = IMEM_AW'(ir_q[DMEM_AW-1:0]);
  assign dmem_addr  = ir_q[DMEM_AW-1:0];
  assign alu_fn     = ir_q[5:0];
  assign imem_wdata = prog_data;
  assign pc         = pc_q;
  assign prog_ready = state_q == S_LOAD;
  assign halted     = state_q == S_HALT;
  assign busy       = state_q inside {S_LOAD, S_FETCH, S_EXEC};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      lp_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      lp_q    <= lp_d;
      ir_q    <= ir_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    lp_d      = lp_q;
    ir_d      = ir_q;
    imem_addr = pc_q;
    imem_we   = 1'b0;
    acc_ld    = 1'b0;
    dmem_we   = 1'b0;
    alu_en    = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (load_start) begin
          state_d = S_LOAD;
          lp_d    = '0;
        end else if (run) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_LOAD: begin
        imem_addr = lp_q;
        imem_we   = prog_valid;
        lp_d      = prog_valid ? lp_q + 1'b1 : lp_q;
        state_d   = (prog_valid && prog_last) ? S_IDLE : S_LOAD;
      end
      S_FETCH: begin
        ir_d    = imem_rdata;
        pc_d    = pc_q + 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        acc_ld  = ir_q[7:6] == OP_LD;
        dmem_we = ir_q[7:6] == OP_ST;
        alu_en  = ir_q[7:6] == OP_ALU;
        state_d = S_FETCH;
        // pc already points past this instruction, so a self-branch targets pc-1
        if (ir_q[7:6] == OP_BNEG && acc_neg) begin
          pc_d    = tgt;
          state_d = (HALT_SELF && tgt == pc_q - 1'b1) ? S_HALT : S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_nano_seq.sv
// tb_nano_seq: directed checks of loading, fetch/decode strobes, branching, halt and wrap corners.
module tb_nano_seq;
  logic clk = 1'b0;
  logic rst_n, load_start, run, prog_valid, prog_last, acc_neg;
  logic [7:0] prog_data, imem_rdata, imem_wdata;
  logic prog_ready, imem_we, acc_ld, dmem_we, alu_en, busy, halted;
  logic [7:0] imem_addr, pc;
  logic [5:0] dmem_addr, alu_fn;
  logic [7:0] mem [256];
  logic [7:0] img [257];
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) if (imem_we) mem[imem_addr] <= imem_wdata;
  assign imem_rdata = mem[imem_addr];
  nano_seq dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .run(run),
    .prog_valid(prog_valid), .prog_data(prog_data), .prog_last(prog_last),
    .prog_ready(prog_ready), .imem_addr(imem_addr), .imem_we(imem_we),
    .imem_wdata(imem_wdata), .imem_rdata(imem_rdata), .dmem_addr(dmem_addr),
    .acc_ld(acc_ld), .dmem_we(dmem_we), .alu_en(alu_en), .alu_fn(alu_fn),
    .acc_neg(acc_neg), .busy(busy), .halted(halted), .pc(pc)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic start_load();
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
  endtask
  task automatic load_bytes(input int n, input int gap_at);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        prog_valid = 1'b0;
        #1;
        check("load_gap_we", imem_we, 0);
        check("load_gap_ready", prog_ready, 1);
        cyc();
      end
      prog_valid = 1'b1;
      prog_data  = img[i];
      prog_last  = (i == n - 1);
      #1;
      check("load_we", imem_we, 1);
      check("load_addr", imem_addr, i % 256);
      check("load_ready", prog_ready, 1);
      cyc();
    end
    prog_valid = 1'b0;
    prog_last  = 1'b0;
    #1;
    check("load_done_ready", prog_ready, 0);
    check("load_done_busy", busy, 0);
  endtask
  task automatic start_run();
    run = 1'b1;
    cyc();
    run = 1'b0;
  endtask
  initial begin
    logic [2:0] exp_s [1:12];
    exp_s = '{3'b000, 3'b100, 3'b000, 3'b010, 3'b000, 3'b001,
              3'b000, 3'b001, 3'b000, 3'b100, 3'b000, 3'b100};
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n = 1'b0; load_start = 1'b0; run = 1'b0; prog_valid = 1'b0;
    prog_last = 1'b0; prog_data = 8'h00; acc_neg = 1'b0;
    cyc(); cyc();
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", pc, 0);
    check("rst_strobes", {acc_ld, dmem_we, alu_en, imem_we, prog_ready}, 0);
    rst_n = 1'b1;
    // LD 2; ST 1; SUB; DECR; LD 0; LD 0; BNEG 0x0A; ... BNEG 0 at 15
    img[0] = 8'h02; img[1] = 8'h41; img[2] = 8'h81; img[3] = 8'h83;
    for (int i = 4; i < 15; i++) img[i] = 8'h00;
    img[6] = 8'hCA; img[15] = 8'hC0;
    start_load();
    check("load_busy", busy, 1);
    load_bytes(16, 4);
    acc_neg = 1'b1;
    start_run();
    for (int c = 1; c <= 15; c++) begin
      if (c % 2 == 1 && c < 15) check("fetch_addr", imem_addr, (c - 1) / 2);
      if (c <= 12) check("strobes", {acc_ld, dmem_we, alu_en}, exp_s[c]);
      if (c == 2)  check("ld_addr", dmem_addr, 2);
      if (c == 4)  check("st_addr", dmem_addr, 1);
      if (c == 6)  check("alu_fn_sub", alu_fn, 6'b000001);
      if (c == 8)  check("alu_fn_decr", alu_fn, 6'b000011);
      if (c == 14) check("bneg_strobes", {acc_ld, dmem_we, alu_en}, 0);
      if (c == 15) check("bneg_taken_addr", imem_addr, 8'h0A);
      cyc();
    end
    acc_neg = 1'b0;
    load_start = 1'b1;
    cyc();
    check("busy_ignores_load", prog_ready, 0);
    load_start = 1'b0;
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_pc", pc, 0);
    check("midrun_rst_strobes", {acc_ld, dmem_we, alu_en, halted}, 0);
    start_run();
    for (int c = 1; c <= 15; c++) begin
      if (c == 15) check("bneg_not_taken_addr", imem_addr, 8'h07);
      cyc();
    end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    img[0] = 8'hC0;
    start_load();
    load_bytes(1, -1);
    acc_neg = 1'b1;
    start_run();
    check("halt_fetch_busy", busy, 1);
    cyc();
    check("halt_exec_halted", halted, 0);
    cyc();
    check("halted", halted, 1);
    check("halted_busy", busy, 0);
    check("halted_pc", pc, 0);
    start_run();
    check("restart_addr", imem_addr, 0);
    check("restart_halted", halted, 0);
    check("restart_busy", busy, 1);
    cyc(); cyc();
    check("rehalt", halted, 1);
    acc_neg = 1'b0;
    run = 1'b1;
    load_start = 1'b1;
    cyc();
    run = 1'b0;
    load_start = 1'b0;
    check("both_load_wins", prog_ready, 1);
    for (int i = 0; i < 257; i++) img[i] = 8'h00;
    img[0] = 8'h3F; img[255] = 8'h10; img[256] = 8'h05;
    load_bytes(257, -1);
    start_run();
    for (int c = 1; c <= 514; c++) begin
      if (c == 2)   check("wrap_load_addr0", dmem_addr, 5);
      if (c == 511) check("fetch_ff", imem_addr, 8'hFF);
      if (c == 512) check("ld_at_ff", {acc_ld, dmem_addr}, {1'b1, 6'h10});
      if (c == 513) check("pc_wrap", imem_addr, 0);
      if (c == 514) check("wrap_exec", {acc_ld, dmem_addr}, {1'b1, 6'h05});
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
